// File: rtl/raycast_pkg.sv
// Shared types and constants for the raycast slice scheduler.
// Angles are signed fixed-point pairs: integer degrees plus thousandths.
package raycast_pkg;

  localparam int ANG_INT_W  = 10;
  localparam int ANG_FRAC_W = 11;
  localparam int FRAC_SCALE = 1000;
  localparam int DEG_FULL   = 360;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_DONE = 3'd2,
    ADVANCE   = 3'd3,
    FINISH    = 3'd4
  } state_t;

endpackage

// File: rtl/angle_wrap_add.sv
// Fixed-point angle adder: the fraction borrows from or carries into the integer,
// and the result is wrapped into 0.000..359.999 degrees.
module angle_wrap_add
  import raycast_pkg::*;
(
  input  logic signed [ANG_INT_W-1:0]  a_x_i,
  input  logic signed [ANG_FRAC_W-1:0] a_y_i,
  input  logic signed [ANG_INT_W-1:0]  b_x_i,
  input  logic signed [ANG_FRAC_W-1:0] b_y_i,
  output logic signed [ANG_INT_W-1:0]  sum_x_o,
  output logic signed [ANG_FRAC_W-1:0] sum_y_o
);

  localparam logic signed [ANG_FRAC_W+1:0] FRAC_S = (ANG_FRAC_W+2)'(FRAC_SCALE);
  localparam logic signed [ANG_INT_W+1:0]  DEG_S  = (ANG_INT_W+2)'(DEG_FULL);
  localparam logic signed [ANG_INT_W+1:0]  ONE_S  = (ANG_INT_W+2)'(1);

  logic signed [ANG_INT_W+1:0]  intSum;
  logic signed [ANG_FRAC_W+1:0] fracSum;

  // Two guard bits cover the borrow/carry and a single 360 wrap in either direction.
  always_comb begin
    fracSum = (ANG_FRAC_W+2)'(a_y_i) + (ANG_FRAC_W+2)'(b_y_i);
    intSum  = (ANG_INT_W+2)'(a_x_i) + (ANG_INT_W+2)'(b_x_i);
    if (fracSum[ANG_FRAC_W+1]) begin
      fracSum = fracSum + FRAC_S;
      intSum  = intSum - ONE_S;
    end else if (fracSum >= FRAC_S) begin
      fracSum = fracSum - FRAC_S;
      intSum  = intSum + ONE_S;
    end
    if (intSum[ANG_INT_W+1]) begin
      intSum = intSum + DEG_S;
    end else if (intSum >= DEG_S) begin
      intSum = intSum - DEG_S;
    end
    sum_x_o = ANG_INT_W'(intSum);
    sum_y_o = ANG_FRAC_W'(fracSum);
  end

endmodule

// File: rtl/raycast_slice_scheduler.sv
// Issues one ray request per screen column and waits for each to complete.
// Define SLICE_TIMEOUT_EN to abandon a slice after 1024 cycles without ray_done.
module raycast_slice_scheduler
  import raycast_pkg::*;
#(
  parameter int NUM_COLS   = 160,
  parameter int STEP_MILLI = 375,
  parameter int FOV_HALF   = 30
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         frame_start,
  input  logic signed [ANG_INT_W-1:0]  player_angle_x,
  input  logic signed [ANG_FRAC_W-1:0] player_angle_y,
  output logic                         ray_valid,
  input  logic                         ray_ready,
  output logic [7:0]                   ray_column,
  output logic signed [ANG_INT_W-1:0]  ray_angle_x,
  output logic signed [ANG_FRAC_W-1:0] ray_angle_y,
  input  logic                         ray_done,
  output logic                         frame_busy,
  output logic                         frame_done,
  output logic                         timeout_err
);

  localparam logic [7:0]                   LAST_COL = 8'(NUM_COLS - 1);
  localparam logic signed [ANG_INT_W-1:0]  FOV_NEG  = ANG_INT_W'(-FOV_HALF);
  localparam logic signed [ANG_FRAC_W:0]   STEP_S   = (ANG_FRAC_W+1)'(STEP_MILLI);
  localparam logic signed [ANG_FRAC_W:0]   FRAC_S   = (ANG_FRAC_W+1)'(FRAC_SCALE);

  state_t                       state_q, state_d;
  logic [7:0]                   column_q, column_d;
  logic signed [ANG_INT_W-1:0]  baseX_q, baseX_d, offX_q, offX_d;
  logic signed [ANG_FRAC_W-1:0] baseY_q, baseY_d, offY_q, offY_d;
  logic signed [ANG_INT_W-1:0]  startX;
  logic signed [ANG_FRAC_W-1:0] startY;
  logic signed [ANG_FRAC_W:0]   stepSum;
  logic                         sliceTimeout;

  angle_wrap_add u_baseAdd (
    .a_x_i   (player_angle_x),
    .a_y_i   (player_angle_y),
    .b_x_i   (FOV_NEG),
    .b_y_i   ('0),
    .sum_x_o (startX),
    .sum_y_o (startY)
  );

  angle_wrap_add u_rayAdd (
    .a_x_i   (baseX_q),
    .a_y_i   (baseY_q),
    .b_x_i   (offX_q),
    .b_y_i   (offY_q),
    .sum_x_o (ray_angle_x),
    .sum_y_o (ray_angle_y)
  );

  assign stepSum = (ANG_FRAC_W+1)'(offY_q) + STEP_S;

  always_comb begin
    state_d  = state_q;
    column_d = column_q;
    baseX_d  = baseX_q;
    baseY_d  = baseY_q;
    offX_d   = offX_q;
    offY_d   = offY_q;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          baseX_d  = startX;
          baseY_d  = startY;
          column_d = '0;
          offX_d   = '0;
          offY_d   = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (ray_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (ray_done || sliceTimeout) begin
          state_d = (column_q == LAST_COL) ? FINISH : ADVANCE;
        end
      end
      ADVANCE: begin
        column_d = column_q + 8'd1;
        if (stepSum >= FRAC_S) begin
          offY_d = ANG_FRAC_W'(stepSum - FRAC_S);
          offX_d = offX_q + 10'sd1;
        end else begin
          offY_d = ANG_FRAC_W'(stepSum);
        end
        state_d = ISSUE;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      column_q <= '0;
      baseX_q  <= '0;
      baseY_q  <= '0;
      offX_q   <= '0;
      offY_q   <= '0;
    end else begin
      state_q  <= state_d;
      column_q <= column_d;
      baseX_q  <= baseX_d;
      baseY_q  <= baseY_d;
      offX_q   <= offX_d;
      offY_q   <= offY_d;
    end
  end

`ifdef SLICE_TIMEOUT_EN
  logic [9:0] tmrCnt_q, tmrCnt_d;
  logic       timeoutErr_q, timeoutErr_d;

  // The last count value stands in for a missing ray_done on the 1024th waiting cycle.
  assign sliceTimeout = (state_q == WAIT_DONE) && (tmrCnt_q == 10'h3FF);

  always_comb begin
    tmrCnt_d     = ((state_q == WAIT_DONE) && !ray_done) ? tmrCnt_q + 10'd1 : '0;
    timeoutErr_d = timeoutErr_q | (sliceTimeout & ~ray_done);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tmrCnt_q     <= '0;
      timeoutErr_q <= 1'b0;
    end else begin
      tmrCnt_q     <= tmrCnt_d;
      timeoutErr_q <= timeoutErr_d;
    end
  end

  assign timeout_err = timeoutErr_q;
`else
  assign sliceTimeout = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  assign ray_valid  = (state_q == ISSUE);
  assign frame_busy = (state_q != IDLE);
  assign frame_done = (state_q == FINISH);
  assign ray_column = column_q;

endmodule

// File: doc/raycast_slice_scheduler.md
RAYCAST_SLICE_SCHEDULER -- requirements
Module: raycast_slice_scheduler

Interface
REQ-001 Parameter NUM_COLS, default 160: screen slices per frame; SHALL be between 1 and 256.
REQ-002 Parameter STEP_MILLI, default 375: per-column angle step in thousandths of a degree.
REQ-003 Parameter FOV_HALF, default 30: half field of view in whole degrees.
REQ-004 clock  in  1  single clock; all logic on its rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 frame_start  in  1  one-cycle request to render a frame.
REQ-007 player_angle_x  in  10 signed  player heading, integer degrees, 0..359.
REQ-008 player_angle_y  in  11 signed  player heading fraction, thousandths, 0..999.
REQ-009 ray_valid  out  1  slice request to the ray engine.
REQ-010 ray_ready  in  1  ray engine accepts the request.
REQ-011 ray_column  out  8  current slice index.
REQ-012 ray_angle_x / ray_angle_y  out  10 signed / 11 signed  ray angle, same format as the player angle.
REQ-013 ray_done  in  1  ray engine finished the accepted slice.
REQ-014 frame_busy  out  1  high from frame acceptance until frame_done; frame_done  out  1  one-cycle end-of-frame pulse.
REQ-015 timeout_err  out  1  sticky slice-timeout flag.

Function
REQ-016 States SHALL be IDLE, ISSUE, WAIT_DONE, ADVANCE, FINISH.
REQ-017 IDLE with frame_start=1: latch base = player angle - FOV_HALF.000, wrapped into 0.000..359.999; clear column and offset to 0; go to ISSUE.
REQ-018 ISSUE: ray_valid=1; ray_angle = base + offset, wrapped; ray_valid=1 and ray_ready=1 in the same cycle is acceptance; go to WAIT_DONE.
REQ-019 While ray_valid=1 and ray_ready=0, ray_column and ray_angle SHALL hold stable.
REQ-020 WAIT_DONE with ray_done=1: go to FINISH if column==NUM_COLS-1, else go to ADVANCE.
REQ-021 ADVANCE: column += 1; offset_y += STEP_MILLI; if the sum is >= 1000, subtract 1000 from offset_y and carry 1 into offset_x; go to ISSUE.
REQ-022 Angle wrap: fraction borrow adds 1000 to the fraction and takes 1 from the integer; integer < 0 adds 360; integer >= 360 subtracts 360.
REQ-023 FINISH: frame_done=1 for exactly one cycle; return to IDLE.
REQ-024 frame_start outside IDLE SHALL be ignored and not queued; ray_done outside WAIT_DONE SHALL be ignored.
REQ-025 Latency: ray_valid SHALL rise 1 cycle after frame_start is sampled in IDLE.
REQ-026 frame_busy SHALL be 1 in every state except IDLE.

Reset
REQ-027 resetn=0 SHALL immediately force IDLE, including mid-frame, and clear all outputs, column, offset and timeout_err to 0.

Configuration
REQ-028 With SLICE_TIMEOUT_EN defined:
- a 10-bit counter runs in WAIT_DONE;
- after 1024 cycles without ray_done, set timeout_err=1 and proceed as if ray_done had arrived.
REQ-029 Without SLICE_TIMEOUT_EN: WAIT_DONE waits indefinitely and timeout_err is tied to 0.

Structure
REQ-030 Shared package raycast_pkg SHALL hold:
- the state enum;
- FRAC_SCALE=1000 and DEG_FULL=360;
- the angle integer and fraction widths (10 and 11).
REQ-031 One sub-module, angle_wrap_add, SHALL implement the signed fixed-point add with fraction borrow/carry and 0..360 wrap; it SHALL be used for the base calculation and the ray angle.

Verification
REQ-032 Reset: hold resetn=0 -> all outputs 0, frame_busy=0.
REQ-033 Player 90.000, ray_ready=1, ray_done 1 cycle after acceptance -> column 0 at 60.000, column 1 at 60.375, column 8 at 63.000, column 159 at 119.625; exactly one frame_done after the 160th ray_done.
REQ-034 Wrap: player 10.500 -> column 0 at 340.500, column 54 at 0.750.
REQ-035 Backpressure: hold ray_ready=0 for 5 cycles during ISSUE -> ray_valid, column and angle remain constant.
REQ-036 frame_start during WAIT_DONE -> ignored; resetn pulse at column 40 -> IDLE next cycle, frame_busy=0.
REQ-037 With SLICE_TIMEOUT_EN: withhold ray_done for 1024 cycles -> timeout_err=1 and column advances; without the macro -> state stays WAIT_DONE.
